// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART responder behind the MEM stage strobes.
// Offsets (addr[7:0]): 0x18 TXD (W), 0x1C RXD (R), 0x20 CON (R).
// um_rd/um_wr are single-cycle strobes with no ready/stall: a strobe is
// always accepted on the posedge where it is high, and read data is
// combinational so the MEM stage can latch it in the same cycle.
module uart_mmio #(
    parameter int BAUD_DIV = 10416
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        um_rd,
    input  logic        um_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] um_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        rx_irq
);

    localparam logic [7:0]  OFF_TXD   = 8'h18;
    localparam logic [7:0]  OFF_RXD   = 8'h1C;
    localparam logic [7:0]  OFF_CON   = 8'h20;
    // Last count of a full bit period and of the half period used to
    // reach the middle of the start bit.
    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic txd_wr;
    logic rxd_rd;
    logic con_rd;

    assign txd_wr = um_wr && (addr[7:0] == OFF_TXD);
    assign rxd_rd = um_rd && (addr[7:0] == OFF_RXD);
    assign con_rd = um_rd && (addr[7:0] == OFF_CON);

    // Upper address bits are decoded by the MEM stage; only the low byte of
    // write data is transmitted.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr[31:8], wdata[31:8]};

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    logic       tx_busy;
    logic       tx_done;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic [7:0] rx_byte;

    assign rx_irq = rx_valid;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    uart_state_t tx_state;
    uart_state_t tx_state_n;
    logic [15:0] tx_cnt;
    logic [15:0] tx_cnt_n;
    logic [2:0]  tx_idx;
    logic [2:0]  tx_idx_n;
    logic [7:0]  tx_shift;
    logic [7:0]  tx_shift_n;
    logic        tx_line_n;
    logic        tx_busy_n;
    logic        tx_done_set;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // TX state register; reset forces the line idle-high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= 16'd0;
            tx_idx   <= 3'd0;
            tx_shift <= 8'd0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_line_n;
            tx_busy  <= tx_busy_n;
        end
    end

    // TX next state: a TXD write in IDLE starts the start bit on the same
    // edge; writes in any other state are dropped.
    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt;
        tx_idx_n    = tx_idx;
        tx_shift_n  = tx_shift;
        tx_line_n   = uart_tx;
        tx_busy_n   = tx_busy;
        tx_done_set = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (txd_wr) begin
                    tx_state_n = ST_START;
                    tx_cnt_n   = 16'd0;
                    tx_idx_n   = 3'd0;
                    tx_shift_n = wdata[7:0];
                    tx_line_n  = 1'b0;
                    tx_busy_n  = 1'b1;
                end
            end
            ST_START: begin
                if (tx_bit_end) begin
                    tx_state_n = ST_DATA;
                    tx_cnt_n   = 16'd0;
                    tx_line_n  = tx_shift[0];
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_n   = 16'd0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_idx == 3'd7) begin
                        tx_state_n = ST_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_idx_n  = tx_idx + 3'd1;
                        tx_line_n = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    tx_state_n  = ST_IDLE;
                    tx_cnt_n    = 16'd0;
                    tx_busy_n   = 1'b0;
                    tx_done_set = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            default: begin
                tx_state_n = ST_IDLE;
                tx_cnt_n   = 16'd0;
                tx_line_n  = 1'b1;
                tx_busy_n  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic        rx_meta;
    logic        rxs;
    uart_state_t rx_state;
    uart_state_t rx_state_n;
    logic [15:0] rx_cnt;
    logic [15:0] rx_cnt_n;
    logic [2:0]  rx_idx;
    logic [2:0]  rx_idx_n;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_shift_n;
    logic        rx_armed;
    logic        rx_armed_n;
    logic        rx_good;
    logic        rx_bad;
    logic        rx_bit_end;
    logic        rx_half_end;

    assign rx_bit_end  = (rx_cnt == BIT_LAST);
    assign rx_half_end = (rx_cnt == HALF_LAST);

    // Two-stage synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    // RX state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= 16'd0;
            rx_idx   <= 3'd0;
            rx_shift <= 8'd0;
            rx_armed <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_armed <= rx_armed_n;
        end
    end

    // RX next state: a falling edge (only after the line was seen high) is
    // confirmed mid start bit, then each bit is sampled at its middle.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_armed_n = rx_armed;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_armed && !rxs) begin
                    rx_state_n = ST_START;
                    rx_cnt_n   = 16'd0;
                end else begin
                    rx_armed_n = rx_armed | rxs;
                end
            end
            ST_START: begin
                if (rx_half_end) begin
                    rx_cnt_n = 16'd0;
                    if (rxs) begin
                        // Too short to be a start bit: ignore it silently.
                        rx_state_n = ST_IDLE;
                    end else begin
                        rx_state_n = ST_DATA;
                        rx_idx_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = 16'd0;
                    rx_shift_n = {rxs, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
                        rx_state_n = ST_STOP;
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_bit_end) begin
                    rx_state_n = ST_IDLE;
                    rx_cnt_n   = 16'd0;
                    rx_armed_n = 1'b0;
                    rx_good    = rxs;
                    rx_bad     = ~rxs;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            default: begin
                rx_state_n = ST_IDLE;
                rx_cnt_n   = 16'd0;
                rx_armed_n = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Flag update: a set on the same edge as a clearing read wins.
    // ------------------------------------------------------------------
    logic       rx_valid_n;
    logic       overrun_n;
    logic       frame_err_n;
    logic       tx_done_n;
    logic [7:0] rx_byte_n;

    // Next flag values from frame events and clearing reads.
    always_comb begin
        rx_valid_n  = rx_good | (rx_valid & ~rxd_rd);
        rx_byte_n   = rx_good ? rx_shift : rx_byte;
        // A byte landing while the previous one is being read is not lost.
        overrun_n   = (rx_good & rx_valid & ~rxd_rd) | (overrun & ~con_rd);
        frame_err_n = rx_bad | (frame_err & ~con_rd);
        tx_done_n   = tx_done_set | (tx_done & ~con_rd);
    end

    // Flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid  <= 1'b0;
            rx_byte   <= 8'd0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            rx_valid  <= rx_valid_n;
            rx_byte   <= rx_byte_n;
            overrun   <= overrun_n;
            frame_err <= frame_err_n;
            tx_done   <= tx_done_n;
        end
    end

    // Read mux: returns pre-clear values; zero when no read is strobed.
    always_comb begin
        um_data = 32'd0;
        if (um_rd) begin
            case (addr[7:0])
                OFF_RXD: um_data = {24'd0, rx_byte};
                OFF_CON: um_data = {27'd0, frame_err, overrun, tx_done, rx_valid, tx_busy};
                default: um_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio at BAUD_DIV=16: directed steps plus random bytes,
// checked against a flag/byte model of the UART register behaviour.
module tb_uart_mmio;

    localparam int         BD        = 16;
    localparam logic [7:0] OFF_TXD   = 8'h18;
    localparam logic [7:0] OFF_RXD   = 8'h1C;
    localparam logic [7:0] OFF_CON   = 8'h20;
    // Edge (counted from the cycle the start bit is driven) on which a
    // received frame completes: 2 sync stages, detection, half start bit,
    // eight data bits and the stop bit.
    localparam int         RX_DONE_J = 2 + BD / 2 + 9 * BD;

    logic        clk = 1'b0;
    logic        reset;
    logic        um_rd;
    logic        um_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] um_data;
    logic        uart_rx;
    logic        uart_tx;
    logic        rx_irq;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the visible register state.
    bit         m_busy, m_txd, m_rxv, m_ovr, m_ferr;
    logic [7:0] m_byte;

    // Expected serial bits of the frame being transmitted.
    logic [0:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1, "timeout");
    end

    uart_mmio #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .reset   (reset),
        .um_rd   (um_rd),
        .um_wr   (um_wr),
        .addr    (addr),
        .wdata   (wdata),
        .um_data (um_data),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .rx_irq  (rx_irq)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] con_exp();
        return {27'd0, m_ferr, m_ovr, m_txd, m_rxv, m_busy};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_txd = 1'b0; m_rxv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        m_byte = 8'h00;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a posedge; takes exactly one cycle.
    task automatic do_read(input logic [7:0] off, output logic [31:0] d);
        um_rd = 1'b1;
        addr  = 32'h4000_0000 | {24'd0, off};
        @(negedge clk);
        d = um_data;
        @(posedge clk);
        #1;
        um_rd = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] off, input logic [31:0] v);
        um_wr = 1'b1;
        addr  = 32'h4000_0000 | {24'd0, off};
        wdata = v;
        @(posedge clk);
        #1;
        um_wr = 1'b0;
    endtask

    task automatic con_check(input string tag);
        logic [31:0] d;
        do_read(OFF_CON, d);
        check(tag, d, con_exp());
        m_txd = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic rxd_check(input string tag);
        logic [31:0] d;
        do_read(OFF_RXD, d);
        check(tag, d, {24'd0, m_byte});
        m_rxv = 1'b0;
    endtask

    // Send byte b on TXD and check every bit mid-period; optionally try a
    // second write while busy (must be dropped). CON is read mid-frame.
    task automatic tx_frame(input logic [7:0] b, input bit extra, input logic [7:0] b2);
        logic [0:0] e;
        do_write(OFF_TXD, {24'd0, b});
        m_busy = 1'b1;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(1'b1);
        for (int c = 0; c < 10 * BD; c++) begin
            if (c % BD == BD / 2) begin
                e = exp_q.pop_front();
                check($sformatf("tx_bit%0d_%02h", c / BD, b), {31'd0, uart_tx}, {31'd0, e});
            end
            if (extra && c == 3 * BD + 3) do_write(OFF_TXD, {24'd0, b2});
            else if (c == 5 * BD + 2) con_check("con_mid_tx");
            else tick(1);
        end
        m_busy = 1'b0;
        m_txd  = 1'b1;
    endtask

    // Drive one 8N1 frame on uart_rx; optionally read RXD on the cycle
    // whose closing edge completes the frame.
    task automatic rx_send(input logic [7:0] b, input bit stop, input int read_at);
        logic [9:0]  frame;
        logic [31:0] d;
        bit          coincide;
        coincide = 1'b0;
        frame    = {stop, b, 1'b0};
        for (int j = 0; j < 10 * BD; j++) begin
            uart_rx = frame[j / BD];
            if (j == read_at) begin
                do_read(OFF_RXD, d);
                check("rxd_at_completion", d, {24'd0, m_byte});
                coincide = 1'b1;
            end else begin
                tick(1);
            end
        end
        uart_rx = 1'b1;
        if (stop) begin
            if (m_rxv && !coincide) m_ovr = 1'b1;
            m_byte = b;
            m_rxv  = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] d;
        logic [7:0]  rb;
        bit          rstop;

        reset = 1'b1; um_rd = 1'b0; um_wr = 1'b0; addr = 32'd0; wdata = 32'd0; uart_rx = 1'b1;
        model_reset();
        #1;
        check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_rx_irq", {31'd0, rx_irq}, 32'd0);
        tick(3);
        reset = 1'b0;
        tick(3);

        // Reset state and decode corners
        con_check("reset_con");
        rxd_check("reset_rxd");
        addr = 32'h4000_0000 | {24'd0, OFF_CON};
        #1;
        check("no_rd_zero", um_data, 32'd0);
        do_read(8'h24, d);
        check("unmapped_read", d, 32'd0);
        do_write(OFF_RXD, 32'hFF);
        do_write(OFF_CON, 32'hFF);
        tick(3);
        check("ignored_write_line", {31'd0, uart_tx}, 32'd1);
        con_check("ignored_write_con");

        // 1: transmit 0xA5, done flag cleared by CON read
        tx_frame(8'hA5, 1'b0, 8'h00);
        con_check("tx_done_con");
        con_check("tx_done_cleared");

        // 2: receive 0x3C
        tick(5);
        rx_send(8'h3C, 1'b1, -1);
        check("rx_irq_set", {31'd0, rx_irq}, {31'd0, m_rxv});
        con_check("rx_con");
        rxd_check("rx_byte_3c");
        con_check("rx_con_after_read");

        // 3: two frames without reading -> overrun, newest byte kept
        rx_send(8'h11, 1'b1, -1);
        rx_send(8'h22, 1'b1, -1);
        tick(2);
        con_check("overrun_con");
        rxd_check("overrun_rxd");

        // 4: bad stop bit, then a short glitch
        rx_send(8'hE7, 1'b0, -1);
        tick(4);
        check("ferr_rx_irq", {31'd0, rx_irq}, {31'd0, m_rxv});
        con_check("ferr_con");
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(3 * BD);
        con_check("glitch_con");
        check("glitch_rx_irq", {31'd0, rx_irq}, 32'd0);

        // 5: second write while busy is dropped
        tx_frame(8'h55, 1'b1, 8'h66);
        for (int k = 0; k < 8; k++) begin
            tick(4);
            check("tx_idle_after", {31'd0, uart_tx}, 32'd1);
        end
        con_check("drop_con");

        // Random transmit bytes
        for (int n = 0; n < 3; n++) begin
            tx_frame(8'($urandom_range(0, 255)), 1'b0, 8'h00);
            tick($urandom_range(1, 5));
        end
        con_check("rand_tx_con");

        // Random receive frames, random stop bit, random read-back
        for (int n = 0; n < 5; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            rx_send(rb, rstop, -1);
            tick(4);
            check("rand_rx_irq", {31'd0, rx_irq}, {31'd0, m_rxv});
            if ($urandom_range(0, 1) == 1) begin
                con_check("rand_rx_con");
                rxd_check("rand_rx_rxd");
            end
        end
        con_check("rand_rx_final_con");

        // 6: reset in the middle of a TX and an RX frame
        rx_send(8'h77, 1'b1, -1);
        tick(2);
        do_write(OFF_TXD, 32'hF0);
        m_busy  = 1'b1;
        uart_rx = 1'b0;
        tick(2 * BD + 5);
        reset = 1'b1;
        #1;
        model_reset();
        check("midreset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("midreset_rx_irq", {31'd0, rx_irq}, 32'd0);
        um_rd = 1'b1;
        addr  = 32'h4000_0000 | {24'd0, OFF_CON};
        #1;
        check("midreset_con", um_data, 32'd0);
        um_rd = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        reset   = 1'b0;
        tick(4);
        con_check("post_reset_con");
        rxd_check("post_reset_rxd");
        rx_send(8'h5A, 1'b1, -1);
        tick(2);
        rx_send(8'hC3, 1'b1, RX_DONE_J);
        tick(2);
        check("coincide_rx_irq", {31'd0, rx_irq}, 32'd1);
        con_check("coincide_con");
        rxd_check("coincide_rxd");
        tx_frame(8'($urandom_range(0, 255)), 1'b0, 8'h00);
        con_check("post_reset_tx_con");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
